// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the scanout and its frame buffer.
//   - Default 640x480@60 timing, used as the parameter defaults of vga_scanout.
//   - Frame-buffer geometry: 320x240 pixels, 3 bits per pixel, 17-bit address.
//   - Colour-bit mapping of a 3-bit pixel: [2]=R, [1]=G, [0]=B.
package vga_pkg;

   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int CNT_W    = 10;
   localparam int FB_W     = 320;
   localparam int FB_H     = 240;
   localparam int FB_WORDS = 76800;
   localparam int FB_AW    = 17;
   localparam int PIX_W    = 3;

   localparam int COL_R = 2;
   localparam int COL_G = 1;
   localparam int COL_B = 0;

   typedef logic [PIX_W-1:0] color_t;

   // Raw or delayed sync/visible flags; syncs are active-high internally.
   typedef struct packed {
      logic hs;
      logic vs;
      logic vis;
   } flags_t;

   // A colour channel is fully on only inside the visible window.
   function automatic logic [7:0] chan(input logic vis, input logic bit_on);
      return (vis && bit_on) ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port frame-buffer RAM.
//   clk      : clock for both ports
//   we_i     : write strobe
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : registered read data, one clk after raddr_i
// A read of the address being written on the same edge returns the old word.
// Contents are never reset.
module fb_dpram #(
   parameter int AW    = 17,
   parameter int DW    = 3,
   parameter int DEPTH = 76800
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Both ports sample the array before the write lands -> read-old behaviour.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 320x240x3 frame buffer scanned out as a 2x-upscaled VGA frame.
//   clk          : system clock (pixel rate is clk/2)
//   iResetn      : asynchronous active-low reset
//   x, y, color  : pixel write column/row/colour, writeEn strobes one write per clk
//   V_SYNC       : copy of VGA_VS for the drawing side
//   VGA_CLK      : pixel clock (pixel-enable register)
//   VGA_HS/VS    : active-low syncs
//   VGA_BLANK_N  : high inside the visible window
//   VGA_R/G/B    : 8-bit channels, all-ones or all-zeros per colour bit
// All VGA outputs lag the counter state by two clk (address reg, RAM/flag reg).
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_VIS    = H_VIS_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_VIS    = V_VIS_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC_W = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clk,
   input  logic       iResetn,
   input  logic [8:0] x,
   input  logic [7:0] y,
   input  logic [2:0] color,
   input  logic       writeEn,
   output logic       V_SYNC,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC_W + V_BP;
   localparam int HS_BEG = H_VIS + H_FP;
   localparam int HS_END = HS_BEG + H_SYNC;
   localparam int VS_BEG = V_VIS + V_FP;
   localparam int VS_END = VS_BEG + V_SYNC_W;

   logic             run_q;
   logic             pen_q, pen_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   flags_t           raw;
   logic [FB_AW-1:0] raddr_d, raddr_q;
   flags_t           st1_q, st2_q;
   color_t           rdata;
   logic             wr_ok;
   logic [FB_AW-1:0] waddr;

   // Pixel enable and raster counters. run_q holds pen low for one extra clk
   // after reset release so the first pen=1 lands on the second edge.
   always_comb begin
      pen_d  = run_q ? ~pen_q : 1'b0;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pen_q) begin
         if (hcnt_q == CNT_W'(H_TOT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == CNT_W'(V_TOT - 1)) ? '0 : vcnt_q + 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
         end
      end
   end

   // Sync/visible decode and upscaled read address. The address is parked at 0
   // outside the visible window so the RAM is never read out of range.
   always_comb begin
      raw.hs  = (hcnt_q >= CNT_W'(HS_BEG)) && (hcnt_q < CNT_W'(HS_END));
      raw.vs  = (vcnt_q >= CNT_W'(VS_BEG)) && (vcnt_q < CNT_W'(VS_END));
      raw.vis = (hcnt_q < CNT_W'(H_VIS)) && (vcnt_q < CNT_W'(V_VIS));
      raddr_d = '0;
      if (raw.vis)
         raddr_d = FB_AW'(vcnt_q[CNT_W-1:1]) * FB_AW'(FB_W) + FB_AW'(hcnt_q[CNT_W-1:1]);
   end

   always_ff @(posedge clk or negedge iResetn) begin
      if (!iResetn) begin
         run_q   <= 1'b0;
         pen_q   <= 1'b0;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         raddr_q <= '0;
         st1_q   <= '0;
         st2_q   <= '0;
      end else begin
         run_q   <= 1'b1;
         pen_q   <= pen_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         raddr_q <= raddr_d;
         st1_q   <= raw;
         st2_q   <= st1_q;
      end
   end

   // Out-of-range coordinates are dropped rather than wrapped into the array;
   // writes are also blocked while reset is held.
   assign wr_ok = writeEn && iResetn && (x < 9'(FB_W)) && (y < 8'(FB_H));
   assign waddr = FB_AW'(y) * FB_AW'(FB_W) + FB_AW'(x);

   fb_dpram #(
      .AW    (FB_AW),
      .DW    (PIX_W),
      .DEPTH (FB_WORDS)
   ) u_fb (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (waddr),
      .wdata_i (color),
      .raddr_i (raddr_q),
      .rdata_o (rdata)
   );

   assign VGA_CLK     = pen_q;
   assign VGA_HS      = ~st2_q.hs;
   assign VGA_VS      = ~st2_q.vs;
   assign V_SYNC      = ~st2_q.vs;
   assign VGA_BLANK_N = st2_q.vis;
   assign VGA_R       = chan(st2_q.vis, rdata[COL_R]);
   assign VGA_G       = chan(st2_q.vis, rdata[COL_G]);
   assign VGA_B       = chan(st2_q.vis, rdata[COL_B]);

endmodule
